// File: rtl/cphy_decoder.sv
// C-PHY receive symbol decoder: turns successive trio wire states into
// {Flip, Rot, Pol} symbols, flags protocol errors and counts them.
module cphy_decoder #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 RxSymbolClkHS,
  input  logic                 Rst,
  input  logic                 DecoderEn,
  input  logic [2:0]           WireState,
  input  logic                 ErrCntClr,
  output logic [2:0]           Sym,
  output logic                 SymValid,
  output logic                 SymErr,
  output logic [1:0]           SymErrCode,
  output logic                 Locked,
  output logic [ERR_CNT_W-1:0] ErrCnt
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_DECODE  = 2'd2
  } state_t;

  localparam logic [1:0] CODE_NONE    = 2'b00;
  localparam logic [1:0] CODE_ILLEGAL = 2'b01;
  localparam logic [1:0] CODE_REPEAT  = 2'b10;

  state_t                 state_q, state_d;
  logic [2:0]             prev_q, prev_d;
  logic [2:0]             sym_q, sym_d;
  logic                   sym_valid_q, sym_valid_d;
  logic                   sym_err_q, sym_err_d;
  logic [1:0]             sym_err_code_q, sym_err_code_d;
  logic                   locked_q, locked_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

  function automatic logic ws_is_legal(input logic [2:0] ws);
    return (ws != 3'b000) && (ws != 3'b111);
  endfunction

  // Legal positive states have one bit set, negative ones two: odd parity means positive.
  function automatic logic ws_sign(input logic [2:0] ws);
    return ^ws;
  endfunction

  // Letter index: 0 = X, 1 = Y, 2 = Z; negative states are the complement of positive ones.
  function automatic logic [1:0] ws_letter(input logic [2:0] ws);
    logic [2:0] pos;
    pos = ws_sign(ws) ? ws : ~ws;
    case (pos)
      3'b100:  return 2'd0;
      3'b010:  return 2'd1;
      default: return 2'd2;
    endcase
  endfunction

  function automatic logic [2:0] decode_sym(input logic [2:0] prev, input logic [2:0] cur);
    logic [1:0] lp;
    logic [1:0] lc;
    logic [1:0] lp_cw;
    logic       rot;
    logic       pol;
    lp    = ws_letter(prev);
    lc    = ws_letter(cur);
    lp_cw = (lp == 2'd2) ? 2'd0 : lp + 2'd1;
    rot   = (lc == lp_cw);
    pol   = ws_sign(prev) ^ ws_sign(cur);
    if (lc == lp) begin
      return 3'b100;
    end
    return {1'b0, rot, pol};
  endfunction

  logic ws_legal;
  assign ws_legal = ws_is_legal(WireState);

  always_comb begin
    state_d        = state_q;
    prev_d         = prev_q;
    sym_d          = sym_q;
    sym_valid_d    = 1'b0;
    sym_err_d      = 1'b0;
    sym_err_code_d = CODE_NONE;
    locked_d       = 1'b0;
    err_cnt_d      = err_cnt_q;

    if (!DecoderEn) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_ACQUIRE;
        end
        ST_ACQUIRE: begin
          if (ws_legal) begin
            prev_d  = WireState;
            state_d = ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (!ws_legal) begin
            sym_err_d      = 1'b1;
            sym_err_code_d = CODE_ILLEGAL;
            state_d        = ST_ACQUIRE;
          end else if (WireState == prev_q) begin
            sym_err_d      = 1'b1;
            sym_err_code_d = CODE_REPEAT;
          end else begin
            sym_valid_d = 1'b1;
            sym_d       = decode_sym(prev_q, WireState);
            prev_d      = WireState;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    locked_d = (state_d == ST_DECODE);

    // Clear wins over a same-cycle error; the count sticks at all-ones.
    if (ErrCntClr) begin
      err_cnt_d = '0;
    end else if (sym_err_d && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge RxSymbolClkHS or posedge Rst) begin
    if (Rst) begin
      state_q        <= ST_IDLE;
      prev_q         <= 3'b000;
      sym_q          <= 3'b000;
      sym_valid_q    <= 1'b0;
      sym_err_q      <= 1'b0;
      sym_err_code_q <= CODE_NONE;
      locked_q       <= 1'b0;
      err_cnt_q      <= '0;
    end else begin
      state_q        <= state_d;
      prev_q         <= prev_d;
      sym_q          <= sym_d;
      sym_valid_q    <= sym_valid_d;
      sym_err_q      <= sym_err_d;
      sym_err_code_q <= sym_err_code_d;
      locked_q       <= locked_d;
      err_cnt_q      <= err_cnt_d;
    end
  end

  assign Sym        = sym_q;
  assign SymValid   = sym_valid_q;
  assign SymErr     = sym_err_q;
  assign SymErrCode = sym_err_code_q;
  assign Locked     = locked_q;
  assign ErrCnt     = err_cnt_q;

endmodule

// File: tb/tb_cphy_decoder.sv
// Randomised bench for cphy_decoder against a rule-level reference model,
// including an encoder-model loopback on a random symbol stream.
module tb_cphy_decoder;

  localparam int CW   = 2;
  localparam int CMAX = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [2:0]    ws;
  logic          clr;
  logic [2:0]    sym;
  logic          sym_valid;
  logic          sym_err;
  logic [1:0]    sym_code;
  logic          locked;
  logic [CW-1:0] cnt;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: 0 = idle, 1 = hunting for a legal state, 2 = locked
  int         m_mode;
  logic [2:0] m_prev;
  int e_sym, e_valid, e_err, e_code, e_locked, e_cnt;

  cphy_decoder #(.ERR_CNT_W(CW)) dut (
    .RxSymbolClkHS(clk),
    .Rst(rst),
    .DecoderEn(en),
    .WireState(ws),
    .ErrCntClr(clr),
    .Sym(sym),
    .SymValid(sym_valid),
    .SymErr(sym_err),
    .SymErrCode(sym_code),
    .Locked(locked),
    .ErrCnt(cnt)
  );

  always #5 clk = ~clk;

  function automatic bit legal(input logic [2:0] w);
    return (w != 3'b000) && (w != 3'b111);
  endfunction

  function automatic int letter_of(input logic [2:0] w);
    case (w)
      3'b100, 3'b011: return 0;
      3'b010, 3'b101: return 1;
      default:        return 2;
    endcase
  endfunction

  function automatic int sign_of(input logic [2:0] w);
    return (w == 3'b100 || w == 3'b010 || w == 3'b001) ? 1 : 0;
  endfunction

  function automatic logic [2:0] ws_of(input int l, input int s);
    logic [2:0] base;
    base = (l == 0) ? 3'b100 : (l == 1) ? 3'b010 : 3'b001;
    return (s != 0) ? base : ~base;
  endfunction

  function automatic int decode_ref(input logic [2:0] p, input logic [2:0] c);
    int lp, lc, rot, pol;
    lp = letter_of(p);
    lc = letter_of(c);
    if (lp == lc) return 4;
    rot = (((lc - lp + 3) % 3) == 1) ? 1 : 0;
    pol = (sign_of(p) != sign_of(c)) ? 1 : 0;
    return rot * 2 + pol;
  endfunction

  // Encoder model: next wire state from the previous one and a symbol 0..4
  function automatic logic [2:0] encode_ref(input logic [2:0] p, input int s);
    int lp, sp, lc, sc;
    lp = letter_of(p);
    sp = sign_of(p);
    if (s == 4) begin
      lc = lp;
      sc = 1 - sp;
    end else begin
      lc = (s >= 2) ? (lp + 1) % 3 : (lp + 2) % 3;
      sc = (s % 2 == 1) ? 1 - sp : sp;
    end
    return ws_of(lc, sc);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_prev = 3'b000;
    e_sym = 0; e_valid = 0; e_err = 0; e_code = 0; e_locked = 0; e_cnt = 0;
  endtask

  task automatic model_edge(input bit en_i, input logic [2:0] w, input bit clr_i);
    e_valid = 0; e_err = 0; e_code = 0;
    if (!en_i) m_mode = 0;
    else if (m_mode == 0) m_mode = 1;
    else if (m_mode == 1) begin
      if (legal(w)) begin m_prev = w; m_mode = 2; end
    end else begin
      if (!legal(w)) begin e_err = 1; e_code = 1; m_mode = 1; end
      else if (w == m_prev) begin e_err = 1; e_code = 2; end
      else begin e_valid = 1; e_sym = decode_ref(m_prev, w); m_prev = w; end
    end
    e_locked = (m_mode == 2) ? 1 : 0;
    if (clr_i) e_cnt = 0;
    else if (e_err != 0 && e_cnt < CMAX) e_cnt++;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    $display("%s en=%b ws=%b clr=%b -> sym=%b v=%b err=%b code=%b lk=%b cnt=%0d",
             tag, en, ws, clr, sym, sym_valid, sym_err, sym_code, locked, cnt);
    check({tag, ".sym"},    32'(sym),       e_sym);
    check({tag, ".valid"},  32'(sym_valid), e_valid);
    check({tag, ".err"},    32'(sym_err),   e_err);
    check({tag, ".code"},   32'(sym_code),  e_code);
    check({tag, ".locked"}, 32'(locked),    e_locked);
    check({tag, ".cnt"},    32'(cnt),       e_cnt);
  endtask

  task automatic step(input string tag, input bit en_i, input logic [2:0] w, input bit clr_i);
    en = en_i; ws = w; clr = clr_i;
    @(posedge clk); #1;
    model_edge(en_i, w, clr_i);
    check_all(tag);
  endtask

  task automatic mid_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("rst_async");
    @(posedge clk); #1;
    check_all("rst_hold");
    rst = 1'b0;
  endtask

  task automatic run_seq(input string tag, input logic [2:0] seq[$]);
    foreach (seq[i]) step(tag, 1'b1, seq[i], 1'b0);
  endtask

  initial begin
    logic [2:0] w;
    logic [2:0] lp_ws;
    int s;
    rst = 1'b1; en = 1'b0; ws = 3'b000; clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_all("reset");
    rst = 1'b0;

    for (int i = 0; i < 5; i++) step("t1_idle", 1'b0, 3'($urandom_range(0, 7)), 1'b0);

    // First 100 only moves IDLE to ACQUIRE; the second one locks
    run_seq("t2", '{3'b100, 3'b100, 3'b010, 3'b110, 3'b011, 3'b001, 3'b101});

    step("t3_off", 1'b0, 3'b000, 1'b0);
    run_seq("t3", '{3'b100, 3'b100, 3'b011, 3'b101});

    step("t4_off", 1'b0, 3'b000, 1'b0);
    run_seq("t4", '{3'b100, 3'b100, 3'b100, 3'b010});

    run_seq("t5", '{3'b111, 3'b001, 3'b100});

    for (int i = 0; i < 5; i++) step("t6_sat", 1'b1, 3'b100, 1'b0);
    step("t6_clr", 1'b1, 3'b100, 1'b1);
    step("t6_inc", 1'b1, 3'b100, 1'b0);
    step("t6_sym", 1'b1, 3'b001, 1'b0);
    mid_reset();

    // Loopback through the encoder model on a random symbol stream
    step("lb_off", 1'b0, 3'b000, 1'b0);
    lp_ws = ws_of($urandom_range(0, 2), $urandom_range(0, 1));
    step("lb_acq", 1'b1, lp_ws, 1'b0);
    step("lb_lock", 1'b1, lp_ws, 1'b0);
    for (int i = 0; i < 400; i++) begin
      s = $urandom_range(0, 4);
      w = encode_ref(lp_ws, s);
      step("lb", 1'b1, w, 1'b0);
      check("lb_sym", 32'(sym), s);
      check("lb_err", 32'(sym_err), 0);
      lp_ws = w;
    end

    // Random stress: illegal states, repeats, enable drops, clears and resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) mid_reset();
      if ($urandom_range(0, 2) == 0) w = ws;
      else w = 3'($urandom_range(0, 7));
      step("rnd", ($urandom_range(0, 15) != 0), w, ($urandom_range(0, 19) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
